// File: rtl/rgb_to_luma_pkg.sv
// rgb_to_luma_pkg: coefficient modes, Q8 coefficient sets and lookup for rgb_to_luma_cfg
package rgb_to_luma_pkg;
  localparam int COEF_Q = 8;
  typedef enum logic [1:0] {MODE_BT601, MODE_BT709, MODE_BT2020, MODE_AVG} mode_e;
  typedef struct packed {
    logic [COEF_Q-1:0] r;
    logic [COEF_Q-1:0] g;
    logic [COEF_Q-1:0] b;
  } coef_t;
  function automatic coef_t coef_for_mode(mode_e m);
    return m == MODE_BT601  ? {8'd77, 8'd150, 8'd29} :
           m == MODE_BT709  ? {8'd54, 8'd183, 8'd19} :
           m == MODE_BT2020 ? {8'd67, 8'd174, 8'd15} :
                              {8'd85, 8'd86,  8'd85};
  endfunction
endpackage

// File: rtl/luma_pipe_stage.sv
// luma_pipe_stage: stall-able valid/ready register slice with a W-bit payload
module luma_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/rgb_to_luma_cfg.sv
// rgb_to_luma_cfg: 3-stage AXI4-Stream RGB-to-luma converter, per-frame coefficient select.
// Define RGB_TO_LUMA_ROUND_EN for round-half-up; otherwise the final shift truncates.
module rgb_to_luma_cfg
  import rgb_to_luma_pkg::*;
#(
  parameter int CH_WIDTH  = 8,
  parameter int COEF_FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [3*CH_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CH_WIDTH-1:0]   m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [1:0]            active_mode
);
  localparam int PW = CH_WIDTH + COEF_FRAC;
  localparam int SW = PW + 2;
  localparam logic [SW-1:0] MAX = SW'((1 << CH_WIDTH) - 1);
`ifdef RGB_TO_LUMA_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (COEF_FRAC - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif
  mode_e mode_q, mode_use;
  coef_t c;
  logic acc, v1, v2, r2, r3;
  logic [PW-1:0] cr, cg, cb, pr, pg, pb;
  logic [3*PW+1:0] d1;
  logic [SW-1:0] sum, shifted;
  logic [SW+1:0] d2;
  logic [CH_WIDTH-1:0] y;
  logic [CH_WIDTH+1:0] d3;
  // a start-of-frame beat already uses the mode it latches
  assign acc = s_axis_tvalid && s_axis_tready;
  assign mode_use = acc && s_axis_tuser ? mode_e'(mode) : mode_q;
  assign c = coef_for_mode(mode_use);
  assign cr = PW'(c.r) << (COEF_FRAC - COEF_Q);
  assign cg = PW'(c.g) << (COEF_FRAC - COEF_Q);
  assign cb = PW'(c.b) << (COEF_FRAC - COEF_Q);
  assign pr = PW'(s_axis_tdata[3*CH_WIDTH-1:2*CH_WIDTH]) * cr;
  assign pg = PW'(s_axis_tdata[2*CH_WIDTH-1:CH_WIDTH]) * cg;
  assign pb = PW'(s_axis_tdata[CH_WIDTH-1:0]) * cb;
  assign active_mode = mode_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_BT601;
    else if (acc && s_axis_tuser) mode_q <= mode_e'(mode);
  end
  luma_pipe_stage #(.W(3*PW+2)) u_s1 (
    .clk, .rst_n,
    .in_valid(s_axis_tvalid), .in_ready(s_axis_tready),
    .in_data({pr, pg, pb, s_axis_tlast, s_axis_tuser}),
    .out_valid(v1), .out_ready(r2), .out_data(d1)
  );
  assign sum = SW'(d1[3*PW+1:2*PW+2]) + SW'(d1[2*PW+1:PW+2]) + SW'(d1[PW+1:2]) + RND;
  luma_pipe_stage #(.W(SW+2)) u_s2 (
    .clk, .rst_n,
    .in_valid(v1), .in_ready(r2), .in_data({sum, d1[1:0]}),
    .out_valid(v2), .out_ready(r3), .out_data(d2)
  );
  assign shifted = d2[SW+1:2] >> COEF_FRAC;
  assign y = shifted > MAX ? MAX[CH_WIDTH-1:0] : shifted[CH_WIDTH-1:0];
  luma_pipe_stage #(.W(CH_WIDTH+2)) u_s3 (
    .clk, .rst_n,
    .in_valid(v2), .in_ready(r3), .in_data({y, d2[1:0]}),
    .out_valid(m_axis_tvalid), .out_ready(m_axis_tready), .out_data(d3)
  );
  assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = d3;
endmodule
